// File: rtl/xy_frame_buffer.sv
// xy_frame_buffer: packs paired X/Y samples into 64-bit {Y,X} words and
// writes them into a two-half ping-pong RAM. A completed half is offered to
// the TX engine through dma_req_o/dma_half_o/dma_ack_i while the other half
// fills. The read port has a registered output with 1-cycle latency.
// Optional feature macro: XY_FRAME_HEADER_EN (word 0 of each frame holds a
// {16'hA55A, frame count, timestamp} header instead of a sample).
module xy_frame_buffer #(
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              xy_valid_i,
  input  logic [31:0]       x_dat_i,
  input  logic [31:0]       y_dat_i,
  input  logic [ADDR_W-1:0] xy_buf_addr_i,
  output logic [63:0]       xy_buf_dat_o,
  output logic              dma_req_o,
  output logic              dma_half_o,
  input  logic              dma_ack_i,
  output logic              overrun_o,
  input  logic              overrun_clr_i,
  output logic [15:0]       frame_cnt_o
);

  localparam int PW = ADDR_W - 1;
  localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic          wr_half;
  logic [1:0]    full;
  logic          oldest;

  logic [63:0]   mem [0:(2**ADDR_W)-1];

  logic          ack_ok;
  logic          do_wr;
  logic          last;
  logic [PW-1:0] wr_addr;
  logic [1:0]    full_ack;
  logic [1:0]    full_nxt;
  logic          oldest_nxt;

`ifdef XY_FRAME_HEADER_EN
  // Headers live in their own registers so the header and the first sample
  // can both land on the first-sample cycle with a single RAM write port.
  logic [63:0]   hdr [0:1];
  logic [31:0]   ts;
`endif

  // Next-state of the full flags: ack clears the oldest half first, then a
  // frame completion may set the half being written.
  always_comb begin
    ack_ok   = dma_ack_i & dma_req_o;
    full_ack = full;
    if (ack_ok) full_ack[oldest] = 1'b0;
    do_wr    = (state == FILL) && enable_i && xy_valid_i;
`ifdef XY_FRAME_HEADER_EN
    wr_addr  = (wr_ptr == '0) ? PW'(1) : wr_ptr;
`else
    wr_addr  = wr_ptr;
`endif
    last     = (wr_addr == LAST);
    full_nxt = full_ack;
    if (do_wr && last) full_nxt[wr_half] = 1'b1;
    oldest_nxt = oldest ^ ack_ok;
  end

  // Capture FSM, ping-pong bookkeeping and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      wr_half     <= 1'b0;
      full        <= 2'b00;
      oldest      <= 1'b0;
      dma_req_o   <= 1'b0;
      dma_half_o  <= 1'b0;
      overrun_o   <= 1'b0;
      frame_cnt_o <= 16'd0;
`ifdef XY_FRAME_HEADER_EN
      ts          <= 32'd0;
`endif
    end else begin
`ifdef XY_FRAME_HEADER_EN
      ts          <= ts + 32'd1;
`endif
      full        <= full_nxt;
      oldest      <= oldest_nxt;
      dma_req_o   <= |full_nxt;
      dma_half_o  <= oldest_nxt;
      if (state == STALL && xy_valid_i) overrun_o <= 1'b1;
      else if (overrun_clr_i)           overrun_o <= 1'b0;
      case (state)
        IDLE: begin
          wr_ptr <= '0;
          // never resume into a half that is still waiting for transfer
          if (enable_i) state <= full_nxt[wr_half] ? STALL : FILL;
        end
        FILL: begin
          if (!enable_i) begin
            state  <= IDLE;
            wr_ptr <= '0;
          end else if (do_wr) begin
            if (last) begin
              wr_ptr      <= '0;
              wr_half     <= ~wr_half;
              frame_cnt_o <= frame_cnt_o + 16'd1;
              if (full_ack[~wr_half]) state <= STALL;
            end else begin
              wr_ptr <= wr_addr + PW'(1);
            end
          end
        end
        STALL: begin
          if (!enable_i) begin
            state  <= IDLE;
            wr_ptr <= '0;
          end else if (!full_nxt[wr_half]) begin
            state <= FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample storage write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[{wr_half, wr_addr}] <= {y_dat_i, x_dat_i};
`ifdef XY_FRAME_HEADER_EN
    if (do_wr && wr_ptr == '0) hdr[wr_half] <= {16'hA55A, frame_cnt_o, ts};
`endif
  end

  // Registered read port; a same-cycle write is seen on the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xy_buf_dat_o <= 64'd0;
    end else begin
`ifdef XY_FRAME_HEADER_EN
      if (xy_buf_addr_i[PW-1:0] == '0) xy_buf_dat_o <= hdr[xy_buf_addr_i[ADDR_W-1]];
      else                             xy_buf_dat_o <= mem[xy_buf_addr_i];
`else
      xy_buf_dat_o <= mem[xy_buf_addr_i];
`endif
    end
  end

endmodule

// File: tb/tb_xy_frame_buffer.sv
// Directed bench for xy_frame_buffer (ADDR_W=10, FRAME_LEN=256).
module tb_xy_frame_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        xy_valid_i = 1'b0;
  logic [31:0] x_dat_i = '0;
  logic [31:0] y_dat_i = '0;
  logic [9:0]  xy_buf_addr_i = '0;
  logic [63:0] xy_buf_dat_o;
  logic        dma_req_o;
  logic        dma_half_o;
  logic        dma_ack_i = 1'b0;
  logic        overrun_o;
  logic        overrun_clr_i = 1'b0;
  logic [15:0] frame_cnt_o;

  int asserts = 0;
  int fails   = 0;

  xy_frame_buffer #(.ADDR_W(10), .FRAME_LEN(256)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .xy_valid_i(xy_valid_i),
    .x_dat_i(x_dat_i), .y_dat_i(y_dat_i), .xy_buf_addr_i(xy_buf_addr_i),
    .xy_buf_dat_o(xy_buf_dat_o), .dma_req_o(dma_req_o), .dma_half_o(dma_half_o),
    .dma_ack_i(dma_ack_i), .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  // stimulus helpers: inputs change on the falling edge
  task automatic do_reset();
    rst = 1'b1; enable_i = 1'b0; xy_valid_i = 1'b0; dma_ack_i = 1'b0;
    overrun_clr_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start();
    enable_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic burst(input int n, input logic [31:0] xb, input logic [31:0] yb, input int ack_at);
    for (int i = 0; i < n; i++) begin
      xy_valid_i = 1'b1;
      x_dat_i = xb + 32'(i);
      y_dat_i = yb + 32'(i);
      dma_ack_i = (i == ack_at);
      @(negedge clk);
    end
    xy_valid_i = 1'b0;
    dma_ack_i = 1'b0;
  endtask

  task automatic pulse_ack();
    dma_ack_i = 1'b1;
    @(negedge clk);
    dma_ack_i = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a);
    xy_buf_addr_i = a;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    asserts++; if (xy_buf_dat_o !== 64'd0) begin fails++; $display("FAIL rst_dat: got %h want 0", xy_buf_dat_o); end
    asserts++; if (dma_req_o !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", dma_req_o); end
    asserts++; if (dma_half_o !== 1'b0) begin fails++; $display("FAIL rst_half: got %b want 0", dma_half_o); end
    asserts++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL rst_ovr: got %b want 0", overrun_o); end
    asserts++; if (frame_cnt_o !== 16'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", frame_cnt_o); end
  endtask

`ifdef XY_FRAME_HEADER_EN
  task automatic test_header();
    do_reset();
    start();
    burst(255, 32'h0, 32'h1000, -1);
    asserts++; if (frame_cnt_o !== 16'd1) begin fails++; $display("FAIL hdr_cnt: got %0d want 1", frame_cnt_o); end
    asserts++; if (dma_req_o !== 1'b1) begin fails++; $display("FAIL hdr_req: got %b want 1", dma_req_o); end
    rd(10'd0);
    asserts++; if (xy_buf_dat_o[63:32] !== 32'hA55A0000) begin fails++; $display("FAIL hdr_word: got %h want a55a0000", xy_buf_dat_o[63:32]); end
    rd(10'd1);
    asserts++; if (xy_buf_dat_o !== 64'h0000100000000000) begin fails++; $display("FAIL hdr_s0: got %h want 0000100000000000", xy_buf_dat_o); end
    rd(10'd255);
    asserts++; if (xy_buf_dat_o !== 64'h000010FE000000FE) begin fails++; $display("FAIL hdr_slast: got %h want 000010fe000000fe", xy_buf_dat_o); end
  endtask
`else
  task automatic test_frame();
    do_reset();
    pulse_ack();  // no request pending: must be ignored
    asserts++; if (dma_half_o !== 1'b0) begin fails++; $display("FAIL stray_ack_half: got %b want 0", dma_half_o); end
    start();
    burst(255, 32'h0, 32'h1000, -1);
    asserts++; if (dma_req_o !== 1'b0) begin fails++; $display("FAIL frame_req_early: got %b want 0", dma_req_o); end
    burst(1, 32'd255, 32'h10FF, -1);
    asserts++; if (dma_req_o !== 1'b1) begin fails++; $display("FAIL frame_req: got %b want 1", dma_req_o); end
    asserts++; if (dma_half_o !== 1'b0) begin fails++; $display("FAIL frame_half: got %b want 0", dma_half_o); end
    asserts++; if (frame_cnt_o !== 16'd1) begin fails++; $display("FAIL frame_cnt: got %0d want 1", frame_cnt_o); end
    rd(10'd5);
    asserts++; if (xy_buf_dat_o !== 64'h0000100500000005) begin fails++; $display("FAIL frame_rd5: got %h want 0000100500000005", xy_buf_dat_o); end
  endtask

  task automatic test_pingpong();
    do_reset();
    start();
    burst(300, 32'h0, 32'h1000, -1);
    asserts++; if (dma_half_o !== 1'b0) begin fails++; $display("FAIL pp_half_pre: got %b want 0", dma_half_o); end
    burst(212, 32'd300, 32'h1000 + 32'd300, 0);
    asserts++; if (dma_half_o !== 1'b1) begin fails++; $display("FAIL pp_half_post: got %b want 1", dma_half_o); end
    asserts++; if (dma_req_o !== 1'b1) begin fails++; $display("FAIL pp_req: got %b want 1", dma_req_o); end
    asserts++; if (frame_cnt_o !== 16'd2) begin fails++; $display("FAIL pp_cnt: got %0d want 2", frame_cnt_o); end
    asserts++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL pp_ovr: got %b want 0", overrun_o); end
    rd(10'd517);
    asserts++; if (xy_buf_dat_o !== 64'h0000110500000105) begin fails++; $display("FAIL pp_rd517: got %h want 0000110500000105", xy_buf_dat_o); end
  endtask

  task automatic test_stall();
    do_reset();
    start();
    burst(768, 32'h0, 32'h1000, -1);
    asserts++; if (overrun_o !== 1'b1) begin fails++; $display("FAIL st_ovr: got %b want 1", overrun_o); end
    asserts++; if (frame_cnt_o !== 16'd2) begin fails++; $display("FAIL st_cnt: got %0d want 2", frame_cnt_o); end
    asserts++; if (dma_half_o !== 1'b0) begin fails++; $display("FAIL st_half: got %b want 0", dma_half_o); end
    rd(10'd0);
    asserts++; if (xy_buf_dat_o !== 64'h0000100000000000) begin fails++; $display("FAIL st_keep0: got %h want 0000100000000000", xy_buf_dat_o); end
    pulse_ack();
    asserts++; if (dma_half_o !== 1'b1) begin fails++; $display("FAIL st_ack_half: got %b want 1", dma_half_o); end
    burst(1, 32'hBEEF0000, 32'hCAFE0000, -1);
    rd(10'd0);
    asserts++; if (xy_buf_dat_o !== 64'hCAFE0000BEEF0000) begin fails++; $display("FAIL st_resume: got %h want cafe0000beef0000", xy_buf_dat_o); end
    asserts++; if (overrun_o !== 1'b1) begin fails++; $display("FAIL st_sticky: got %b want 1", overrun_o); end
    overrun_clr_i = 1'b1;
    @(negedge clk);
    overrun_clr_i = 1'b0;
    asserts++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL st_clr: got %b want 0", overrun_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start();
    burst(512, 32'h0, 32'h1000, 511);  // ack half 0 with the completing sample
    asserts++; if (dma_half_o !== 1'b1) begin fails++; $display("FAIL b2b_half: got %b want 1", dma_half_o); end
    asserts++; if (dma_req_o !== 1'b1) begin fails++; $display("FAIL b2b_req: got %b want 1", dma_req_o); end
    asserts++; if (frame_cnt_o !== 16'd2) begin fails++; $display("FAIL b2b_cnt: got %0d want 2", frame_cnt_o); end
    burst(1, 32'h777, 32'h888, -1);
    asserts++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL b2b_ovr: got %b want 0", overrun_o); end
    rd(10'd0);
    asserts++; if (xy_buf_dat_o !== 64'h0000088800000777) begin fails++; $display("FAIL b2b_rd0: got %h want 0000088800000777", xy_buf_dat_o); end
  endtask

  task automatic test_disable();
    do_reset();
    start();
    burst(100, 32'h5000, 32'h5100, -1);
    enable_i = 1'b0;
    @(negedge clk); @(negedge clk);
    asserts++; if (frame_cnt_o !== 16'd0) begin fails++; $display("FAIL dis_cnt0: got %0d want 0", frame_cnt_o); end
    start();
    burst(255, 32'h6000, 32'h7000, -1);
    asserts++; if (frame_cnt_o !== 16'd0) begin fails++; $display("FAIL dis_partial: got %0d want 0", frame_cnt_o); end
    burst(1, 32'h60FF, 32'h70FF, -1);
    asserts++; if (frame_cnt_o !== 16'd1) begin fails++; $display("FAIL dis_cnt1: got %0d want 1", frame_cnt_o); end
    asserts++; if (dma_half_o !== 1'b0) begin fails++; $display("FAIL dis_half: got %b want 0", dma_half_o); end
    rd(10'd0);
    asserts++; if (xy_buf_dat_o !== 64'h0000700000006000) begin fails++; $display("FAIL dis_rd0: got %h want 0000700000006000", xy_buf_dat_o); end
    burst(50, 32'h0, 32'h0, -1);
    #3 rst = 1'b1;
    #1;
    asserts++; if (dma_req_o !== 1'b0) begin fails++; $display("FAIL arst_req: got %b want 0", dma_req_o); end
    asserts++; if (frame_cnt_o !== 16'd0) begin fails++; $display("FAIL arst_cnt: got %0d want 0", frame_cnt_o); end
    asserts++; if (xy_buf_dat_o !== 64'd0) begin fails++; $display("FAIL arst_dat: got %h want 0", xy_buf_dat_o); end
    @(negedge clk);
    rst = 1'b0;
    enable_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef XY_FRAME_HEADER_EN
    test_header();
`else
    test_frame();
    test_pingpong();
    test_stall();
    test_back_to_back();
    test_disable();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
